// File: rtl/pmac_pipe.sv
// pmac_pipe: pipelined Baugh-Wooley multiply-accumulate unit with a
// per-beat signed/unsigned mode, an optional running accumulator and
// valid/ready handshakes with full backpressure.
//
// Stage 1 captures the product of the accepted operands. Stages 2..STAGES-1
// carry it forward. Stage STAGES is the output register, where the
// accumulator add happens.
module pmac_pipe #(
  parameter int AW     = 8,
  parameter int BW     = 9,
  parameter int STAGES = 3,
  parameter int ACCW   = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   a,
  input  logic [BW-1:0]   b,
  input  logic            sgn,
  input  logic            acc_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] p,
  output logic            ovf
);

  localparam int          PW   = AW + BW;
  localparam int          LAST = STAGES - 1;
  localparam int unsigned AMSB = AW - 1;
  localparam int unsigned BMSB = BW - 1;
  // Correction constant for the complemented MSB row/column terms (mod 2^PW).
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << (AW - 1)) + (PW'(1) << (BW - 1))
                                    + (PW'(1) << (PW - 1));

  logic              adv;
  logic              pp;
  logic [PW-1:0]     prod_raw;
  logic [ACCW-1:0]   prod_ext;
  logic [ACCW-1:0]   addend;
  logic [ACCW:0]     sum_w;
  logic              ovf_w;

  logic [STAGES-1:1] vld_q, vld_d;
  logic [STAGES-1:1] tsgn_q, tsgn_d;
  logic [STAGES-1:1] tacc_q, tacc_d;
  logic [ACCW-1:0]   prod_q [1:STAGES-1];
  logic [ACCW-1:0]   prod_d [1:STAGES-1];
  logic              out_valid_q, out_valid_d;
  logic [ACCW-1:0]   p_q, p_d;
  logic              ovf_q, ovf_d;
  logic [ACCW-1:0]   acc_q, acc_d;

  // Global advance: everything moves unless a result is held at the output.
  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_ready = adv;
  end

  // Baugh-Wooley product of the operands presented this cycle.
  always_comb begin
    prod_raw = '0;
    pp       = 1'b0;
    for (int unsigned i = 0; i < AW; i++) begin
      for (int unsigned j = 0; j < BW; j++) begin
        pp = a[i] & b[j];
        if (sgn && ((i == AMSB) != (j == BMSB))) pp = ~pp;
        prod_raw = prod_raw + (PW'(pp) << (i + j));
      end
    end
    if (sgn) prod_raw = prod_raw + BW_CORR;
    prod_ext = sgn ? ACCW'($signed(prod_raw)) : ACCW'(prod_raw);
  end

  // Final-stage accumulate and overflow for the beat leaving the last stage.
  always_comb begin
    addend = tacc_q[LAST] ? acc_q : '0;
    sum_w  = {1'b0, prod_q[LAST]} + {1'b0, addend};
    ovf_w  = 1'b0;
    if (tacc_q[LAST]) begin
      if (!tsgn_q[LAST]) ovf_w = sum_w[ACCW];
      else ovf_w = (prod_q[LAST][ACCW-1] == acc_q[ACCW-1]) &&
                   (sum_w[ACCW-1] != acc_q[ACCW-1]);
    end
  end

  // Next-state: clear flushes, advance shifts every stage, otherwise hold.
  always_comb begin
    vld_d       = vld_q;
    tsgn_d      = tsgn_q;
    tacc_d      = tacc_q;
    prod_d      = prod_q;
    out_valid_d = out_valid_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    if (clr) begin
      vld_d       = '0;
      out_valid_d = 1'b0;
      p_d         = '0;
      ovf_d       = 1'b0;
      acc_d       = '0;
    end else if (adv) begin
      vld_d[1]  = in_valid;
      tsgn_d[1] = sgn;
      tacc_d[1] = acc_en;
      prod_d[1] = prod_ext;
      for (int unsigned s = 2; s < STAGES; s++) begin
        vld_d[s]  = vld_q[s-1];
        tsgn_d[s] = tsgn_q[s-1];
        tacc_d[s] = tacc_q[s-1];
        prod_d[s] = prod_q[s-1];
      end
      out_valid_d = vld_q[LAST];
      if (vld_q[LAST]) begin
        p_d   = sum_w[ACCW-1:0];
        ovf_d = ovf_w;
        acc_d = sum_w[ACCW-1:0];
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      tsgn_q      <= '0;
      tacc_q      <= '0;
      for (int unsigned s = 1; s < STAGES; s++) prod_q[s] <= '0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      vld_q       <= vld_d;
      tsgn_q      <= tsgn_d;
      tacc_q      <= tacc_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pmac_pipe.sv
// Testbench for pmac_pipe (default parameters): directed scenarios plus a
// random phase, checked against an arithmetic scoreboard model.
module tb_pmac_pipe;

  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, sgn, acc_en, out_valid, out_ready, ovf;
  logic [7:0]  a;
  logic [8:0]  b;
  logic [23:0] p;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] p;
    logic        ovf;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] macc;
  logic [23:0] got_p[$];
  logic        got_ovf[$];
  int          got_cyc[$];
  int          cyc = 0, stalls = 0;
  bit          held = 0;
  logic [23:0] held_p;
  logic        held_ovf;
  bit          bp_on = 0;
  int          bp_base = 0, ir_low = 0;
  bit          accd;

  pmac_pipe #(.AW(8), .BW(9), .STAGES(STAGES), .ACCW(24)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .acc_en(acc_en), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product, accumulator as a raw 24-bit value.
  task automatic model_push(input logic [7:0] av, input logic [8:0] bv,
                            input logic sv, input logic ev);
    longint prod, s, sacc;
    exp_t   e;
    if (sv) prod = longint'($signed(av)) * longint'($signed(bv));
    else    prod = longint'(av) * longint'(bv);
    if (!ev) begin
      s = prod;
      e.ovf = 1'b0;
    end else if (!sv) begin
      s = prod + longint'(macc);
      e.ovf = (s >= 64'sd16777216);
    end else begin
      sacc = (macc >= 24'h800000) ? longint'(macc) - 64'sd16777216 : longint'(macc);
      s = sacc + prod;
      e.ovf = (s >= 64'sd8388608) || (s < -64'sd8388608);
    end
    e.p   = s[23:0];
    e.cyc = cyc;
    e.stl = stalls;
    macc  = e.p;
    exp_q.push_back(e);
  endtask

  task automatic model_flush();
    exp_q.delete();
    macc = '0;
    held = 0;
  endtask

  // One clock cycle: observe at the falling edge, then step past the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    acc = 0;
    @(negedge clk);
    if (clr) begin
      model_flush();
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_p", p, held_p);
        chk("hold_ovf", ovf, held_ovf);
      end
      held     = out_valid && !out_ready;
      held_p   = p;
      held_ovf = ovf;
      if (bp_on && !in_ready) ir_low++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stale_valid", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("p", p, e.p);
          chk("ovf", ovf, e.ovf);
          chk("latency", cyc - e.cyc, STAGES + (stalls - e.stl));
          got_p.push_back(p);
          got_ovf.push_back(ovf);
          got_cyc.push_back(cyc);
        end
      end
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready) begin
        model_push(a, b, sgn, acc_en);
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bp_on) out_ready = !((cyc - bp_base) >= 4 && (cyc - bp_base) <= 8);
  endtask

  task automatic beat(input logic [7:0] av, input logic [8:0] bv,
                      input logic sv, input logic ev);
    bit ok = 0;
    a = av; b = bv; sgn = sv; acc_en = ev; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(ok);
      if (ok) break;
    end
    if (!ok) chk("beat_accept", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick(accd);
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic clear_log();
    got_p.delete();
    got_ovf.delete();
    got_cyc.delete();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sgn = 1'b0; acc_en = 1'b0; macc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_ovf", ovf, 0);

    // Signed -128 * 255 with exact latency
    beat(8'h80, 9'h0FF, 1, 0);
    tick(accd);
    tick(accd);
    chk("lat_valid", out_valid, 1);
    chk("lat_p", p, 24'hFF8080);
    chk("lat_ovf", ovf, 0);
    drain();

    // Back-to-back signed then unsigned
    clear_log();
    beat(8'h80, 9'h100, 1, 0);
    beat(8'hFF, 9'h1FF, 0, 0);
    drain();
    chk("b2b_count", got_p.size(), 2);
    chk("b2b_p0", got_p[0], 24'h008000);
    chk("b2b_p1", got_p[1], 24'h01FD01);
    chk("b2b_consecutive", got_cyc[1] - got_cyc[0], 1);

    // Accumulate
    clear_log();
    beat(8'd100, 9'd200, 0, 0);
    beat(8'd100, 9'd200, 0, 1);
    beat(8'd100, 9'd200, 0, 1);
    drain();
    chk("accum_p0", got_p[0], 24'h004E20);
    chk("accum_p1", got_p[1], 24'h009C40);
    chk("accum_p2", got_p[2], 24'h00EA60);

    // Unsigned carry-out on the 129th result
    clear_log();
    beat(8'hFF, 9'h1FF, 0, 0);
    for (int i = 0; i < 128; i++) beat(8'hFF, 9'h1FF, 0, 1);
    drain();
    chk("ovf_count", got_p.size(), 129);
    chk("ovf_last_p", got_p[128], 24'h007D81);
    chk("ovf_last_flag", got_ovf[128], 1);
    begin
      int n = 0;
      for (int i = 0; i < 128; i++) n += int'(got_ovf[i]);
      chk("ovf_early_flags", n, 0);
    end

    // Backpressure window
    clear_log();
    ir_low = 0;
    bp_base = cyc;
    bp_on = 1;
    for (int i = 0; i < 10; i++)
      beat(8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 0);
    drain();
    bp_on = 0;
    out_ready = 1'b1;
    chk("bp_count", got_p.size(), 10);
    chk("bp_stall_cycles", ir_low, 5);

    // Synchronous clear with beats in flight
    beat(8'd100, 9'd200, 0, 0);
    drain();
    beat(8'd1, 9'd2, 0, 1);
    beat(8'd3, 9'd4, 0, 1);
    clr = 1'b1; in_valid = 1'b1; a = 8'd5; b = 9'd6;
    tick(accd);
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    clear_log();
    for (int i = 0; i < 5; i++) tick(accd);
    chk("clr_no_stale", got_p.size(), 0);
    beat(8'd3, 9'd5, 0, 1);
    drain();
    chk("clr_bare_product", got_p[0], 24'd15);

    // Asynchronous reset pulse with beats in flight
    beat(8'd1, 9'd2, 0, 1);
    beat(8'd3, 9'd4, 0, 1);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_flush();
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    clear_log();
    for (int i = 0; i < 5; i++) tick(accd);
    chk("rst_no_stale", got_p.size(), 0);
    beat(8'd7, 9'd9, 0, 1);
    drain();
    chk("rst_bare_product", got_p[0], 24'd63);

    // Random traffic with random backpressure and occasional clear
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      clr       = 1'($urandom_range(0, 49) == 0);
      a         = 8'($urandom_range(0, 255));
      b         = 9'($urandom_range(0, 511));
      sgn       = 1'($urandom_range(0, 1));
      acc_en    = 1'($urandom_range(0, 3) != 0);
      tick(accd);
    end
    clr = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
